i2s_rx: RTL and testbench

- I2S receiver (deserializer): the receive-side counterpart of the i2s transmitter.
- Samples codec ADC serial data (DIN) against externally driven SCLK/LRCLK, all oversampled in the CLK domain.
- Assembles stereo frames and presents them on a valid/ready interface, normally into the record FIFO write port (wrreq/data) on CLK.
- Sits beside synth_ip/i2s in the audio path; feeds line-in capture and monitoring.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sync_edge.sv | 37 +++
 rtl/i2s_rx.sv | 184 ++++++++++++++++++
 tb/tb_i2s_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Types and default sizes shared by the I2S transmit and receive paths.
package i2s_pkg;

   localparam int I2S_DATA_W = 24;
   localparam int I2S_SLOT_W = 32;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for the codec pins, with SCLK rising-edge detect.
// Only SCLK gets an edge detector; the data pins are delayed by the same
// number of stages so they stay aligned with the detected edge.
module i2s_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_N      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk_async,
   input  logic [DATA_N-1:0] data_async,
   output logic              sclk_rise,
   output logic [DATA_N-1:0] data_sync
);

   logic [SYNC_STAGES-1:0] sclk_q;
   logic [DATA_N-1:0]      data_q [SYNC_STAGES];
   logic                   sclk_prev_q;

   // Shift every pin through its synchronizer chain; remember last synced SCLK.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_q      <= '0;
         sclk_prev_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= '0;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_async};
         sclk_prev_q <= sclk_q[SYNC_STAGES-1];
         data_q[0]   <= data_async;
         for (int i = 1; i < SYNC_STAGES; i++) data_q[i] <= data_q[i-1];
      end
   end

   assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
   assign data_sync = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes codec ADC data into stereo frames and hands
// them out over a valid/ready pair. Optional peak meter: I2S_RX_PEAK_EN.
//
// state | meaning
// SEEK  | not aligned; waiting for the start of a left slot
// LEFT  | receiving the left slot
// RIGHT | receiving the right slot; a good close completes the frame
module i2s_rx #(
   parameter int DATA_W      = i2s_pkg::I2S_DATA_W,
   parameter int SLOT_W      = i2s_pkg::I2S_SLOT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SCLK,
   input  logic              LRCLK,
   input  logic              DIN,
   output logic [DATA_W-1:0] LEFT,
   output logic [DATA_W-1:0] RIGHT,
   output logic              SAMPLE_VALID,
   input  logic              SAMPLE_READY,
   output logic              OVERRUN,
   output logic              FRAME_ERR,
   input  logic              PEAK_CLR,
   output logic [DATA_W-1:0] PEAK
);

   import i2s_pkg::*;

   localparam int CNT_W = $clog2(SLOT_W + 1);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W);

   rx_state_t         state_q, state_d;
   logic              sclk_rise;
   logic [1:0]        pins_sync;
   logic              lr_s, din_s;
   logic              lr_prev_q;
   logic              trans;
   logic              slot_good;
   logic              latch_left, frame_good, slot_bad;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] shift_q, left_hold_q, right_hold_q;
   logic              done_q;
   logic              xfer, load_frame;

   i2s_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DATA_N      (2)
   ) u_sync (
      .clk        (CLK),
      .reset      (RESET),
      .sclk_async (SCLK),
      .data_async ({DIN, LRCLK}),
      .sclk_rise  (sclk_rise),
      .data_sync  (pins_sync)
   );

   assign lr_s      = pins_sync[0];
   assign din_s     = pins_sync[1];
   assign trans     = sclk_rise && (lr_s != lr_prev_q);
   assign slot_good = (bit_cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= i2s_pkg::SEEK;
      else       state_q <= state_d;
   end

   // Slot sequencing; everything happens on LRCLK transition edges only.
   always_comb begin
      state_d    = state_q;
      latch_left = 1'b0;
      frame_good = 1'b0;
      slot_bad   = 1'b0;
      if (trans) begin
         case (state_q)
            i2s_pkg::SEEK: begin
               if (!lr_s) state_d = i2s_pkg::LEFT;
            end
            i2s_pkg::LEFT: begin
               if (slot_good) begin
                  latch_left = 1'b1;
                  state_d    = i2s_pkg::RIGHT;
               end else begin
                  slot_bad = 1'b1;
                  state_d  = i2s_pkg::SEEK;
               end
            end
            i2s_pkg::RIGHT: begin
               state_d = i2s_pkg::LEFT;
               if (slot_good) frame_good = 1'b1;
               else           slot_bad   = 1'b1;
            end
            default: state_d = i2s_pkg::SEEK;
         endcase
      end
   end

   // Bit counting and shifting. The right word is copied aside at the
   // closing edge because the shift register is cleared on that same edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         lr_prev_q    <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         left_hold_q  <= '0;
         right_hold_q <= '0;
         done_q       <= 1'b0;
         FRAME_ERR    <= 1'b0;
      end else begin
         done_q <= frame_good;
         if (sclk_rise) begin
            lr_prev_q <= lr_s;
            if (trans) begin
               bit_cnt_q <= '0;
               shift_q   <= '0;
            end else begin
               if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
               if (bit_cnt_q < CNT_DATA) shift_q <= {shift_q[DATA_W-2:0], din_s};
            end
         end
         if (latch_left) left_hold_q  <= shift_q;
         if (frame_good) right_hold_q <= shift_q;
         if (slot_bad)   FRAME_ERR    <= 1'b1;
      end
   end

   assign xfer       = SAMPLE_VALID && SAMPLE_READY;
   assign load_frame = done_q && (!SAMPLE_VALID || xfer);

   // Output hold registers and handshake; a frame arriving while the held
   // one is still pending is dropped and flagged.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         LEFT         <= '0;
         RIGHT        <= '0;
         SAMPLE_VALID <= 1'b0;
         OVERRUN      <= 1'b0;
      end else begin
         if (load_frame) begin
            LEFT         <= left_hold_q;
            RIGHT        <= right_hold_q;
            SAMPLE_VALID <= 1'b1;
         end else if (xfer) begin
            SAMPLE_VALID <= 1'b0;
         end
         if (done_q && SAMPLE_VALID && !SAMPLE_READY) OVERRUN <= 1'b1;
      end
   end

`ifdef I2S_RX_PEAK_EN
   // Magnitude of a two's-complement sample, clamped so the most negative
   // code still fits in DATA_W bits.
   function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
      if (!x[DATA_W-1])                         return x;
      else if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
      else                                      return -x;
   endfunction

   logic [DATA_W-1:0] abs_l, abs_r, peak_max;

   always_comb begin
      abs_l    = sat_abs(left_hold_q);
      abs_r    = sat_abs(right_hold_q);
      peak_max = PEAK;
      if (abs_l > peak_max) peak_max = abs_l;
      if (abs_r > peak_max) peak_max = abs_r;
   end

   // Peak follows only frames that reach the outputs; clear wins over update.
   always_ff @(posedge CLK) begin
      if (RESET)           PEAK <= '0;
      else if (PEAK_CLR)   PEAK <= '0;
      else if (load_frame) PEAK <= peak_max;
   end
`else
   logic unused_peak_clr;
   assign unused_peak_clr = PEAK_CLR;
   assign PEAK            = '0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: CLK 100 MHz, SCLK 3.125 MHz, 24-bit samples in
// 32-bit slots. Build with +define+I2S_RX_PEAK_EN to exercise the peak meter.
module tb_i2s_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        lrclk = 1'b0;
   logic        din = 1'b0;
   logic [23:0] left, right, peak;
   logic        sample_valid, sample_ready = 1'b1;
   logic        overrun, frame_err;
   logic        peak_clr = 1'b0;

   int          n_checks = 0;
   int          n_err = 0;
   int          xcnt = 0;
   int          xbase;
   logic [23:0] last_l = '0, last_r = '0;

   i2s_rx dut (
      .CLK          (clk),
      .RESET        (rst),
      .SCLK         (sclk),
      .LRCLK        (lrclk),
      .DIN          (din),
      .LEFT         (left),
      .RIGHT        (right),
      .SAMPLE_VALID (sample_valid),
      .SAMPLE_READY (sample_ready),
      .OVERRUN      (overrun),
      .FRAME_ERR    (frame_err),
      .PEAK_CLR     (peak_clr),
      .PEAK         (peak)
   );

   always #5 clk = ~clk;

   // Record every accepted frame, sampled away from the active edge.
   always @(negedge clk) begin
      if (sample_valid && sample_ready) begin
         xcnt++;
         last_l = left;
         last_r = right;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic lr, input logic d);
      sclk = 1'b0; lrclk = lr; din = d;
      #160;
      sclk = 1'b1;
      #160;
   endtask

   // Bits first..nbits-1 of a slot; bit 0 is the LRCLK transition edge.
   task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits, input int first);
      logic d;
      for (int i = first; i < nbits; i++) begin
         d = (i >= 1 && i <= 24) ? data[24-i] : 1'b0;
         send_bit(lr, d);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_slot(1'b0, l, 32, 0);
      send_slot(1'b1, r, 32, 0);
   endtask

   // Next left-slot start; this edge completes the preceding frame.
   task automatic close_frame();
      send_bit(1'b0, 1'b0);
   endtask

   // As close_frame, with READY high only in the CLK where the frame loads
   // (SCLK rises on a negedge; two sync flops plus the edge stage put the
   // load on the fourth posedge after the rise).
   task automatic close_frame_ready_pulse();
      sclk = 1'b0; lrclk = 1'b0; din = 1'b0;
      #160;
      sclk = 1'b1;
      #26 sample_ready = 1'b1;
      #10 sample_ready = 1'b0;
      #124;
   endtask

   task automatic prime();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (4) @(negedge clk);
      check("rst_left",  left,         0);
      check("rst_right", right,        0);
      check("rst_valid", sample_valid, 0);
      check("rst_ovr",   overrun,      0);
      check("rst_ferr",  frame_err,    0);
      check("rst_peak",  peak,         0);
      rst = 1'b0;

      // Basic frame after a priming left-slot start
      prime();
      xbase = xcnt;
      send_frame(24'h123456, 24'hABCDEF);
      close_frame();
      check("s1_count", xcnt - xbase, 1);
      check("s1_left",  last_l, 24'h123456);
      check("s1_right", last_r, 24'hABCDEF);
      check("s1_ferr",  frame_err, 0);
      check("s1_valid_drop", sample_valid, 0);

      // Reset released in the middle of a right slot
      @(negedge clk) rst = 1'b1;
      send_slot(1'b0, 24'h777777, 32, 0);
      send_slot(1'b1, 24'h666666, 10, 0);
      rst = 1'b0;
      send_slot(1'b1, 24'h666666, 32, 10);
      xbase = xcnt;
      send_slot(1'b0, 24'h0F0F0F, 32, 0);
      check("s2_none_early", xcnt - xbase, 0);
      send_slot(1'b1, 24'hF0F0F0, 32, 0);
      close_frame();
      check("s2_count", xcnt - xbase, 1);
      check("s2_left",  last_l, 24'h0F0F0F);
      check("s2_right", last_r, 24'hF0F0F0);

      // Overrun: two frames with READY low
      do_reset();
      sample_ready = 1'b0;
      prime();
      xbase = xcnt;
      send_frame(24'h000001, 24'h000002);
      send_frame(24'h000003, 24'h000004);
      close_frame();
      check("s3_valid", sample_valid, 1);
      check("s3_left",  left,    24'h000001);
      check("s3_right", right,   24'h000002);
      check("s3_ovr",   overrun, 1);
      @(negedge clk) sample_ready = 1'b1;
      @(negedge clk);
      check("s3_drain", xcnt - xbase, 1);
      check("s3_valid_drop", sample_valid, 0);

      // Transfer in the same cycle a new frame loads: no overrun
      do_reset();
      sample_ready = 1'b0;
      prime();
      xbase = xcnt;
      send_frame(24'h000001, 24'h000002);
      send_frame(24'h000003, 24'h000004);
      close_frame_ready_pulse();
      check("s3b_first",  last_l, 24'h000001);
      check("s3b_valid",  sample_valid, 1);
      check("s3b_left",   left,    24'h000003);
      check("s3b_right",  right,   24'h000004);
      check("s3b_ovr",    overrun, 0);
      sample_ready = 1'b1;

      // Short right slot: frame discarded, next frame delivered
      do_reset();
      prime();
      xbase = xcnt;
      send_slot(1'b0, 24'h111111, 32, 0);
      send_slot(1'b1, 24'h222222, 31, 0);
      send_frame(24'h00AA55, 24'h55AA00);
      close_frame();
      check("s4_ferr",  frame_err, 1);
      check("s4_count", xcnt - xbase, 1);
      check("s4_left",  last_l, 24'h00AA55);
      check("s4_right", last_r, 24'h55AA00);

      // Reset 10 SCLKs into a left slot, then resync
      send_slot(1'b0, 24'h0, 10, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("s5_left",  left,         0);
      check("s5_right", right,        0);
      check("s5_valid", sample_valid, 0);
      check("s5_ovr",   overrun,      0);
      check("s5_ferr",  frame_err,    0);
      @(negedge clk) rst = 1'b0;
      xbase = xcnt;
      send_slot(1'b0, 24'h0, 32, 10);
      send_slot(1'b1, 24'h0, 32, 0);
      check("s5_none_early", xcnt - xbase, 0);
      send_frame(24'h5A5A5A, 24'h3C3C3C);
      close_frame();
      check("s5_count", xcnt - xbase, 1);
      check("s5_left",  last_l, 24'h5A5A5A);
      check("s5_right", last_r, 24'h3C3C3C);

`ifdef I2S_RX_PEAK_EN
      // Peak meter: saturated magnitude, clear, then a small negative
      do_reset();
      prime();
      send_frame(24'h800000, 24'h000010);
      close_frame();
      check("pk_sat", peak, 24'h7FFFFF);
      @(negedge clk) peak_clr = 1'b1;
      @(negedge clk) peak_clr = 1'b0;
      check("pk_clr", peak, 0);
      send_slot(1'b0, 24'hFFFFF0, 32, 1);
      send_slot(1'b1, 24'h000000, 32, 0);
      close_frame();
      check("pk_neg", peak, 24'h000010);
`else
      check("pk_off", peak, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
